// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED blink controller: command modes, FSM states
// and the fallback half-period used when a command carries H = 0.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ON,
    ST_BLINK,
    ST_BURST_ON,
    ST_BURST_OFF
  } state_e;

  localparam int DEFAULT_HALF_PERIOD_CYC = 5000;

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Command handshake bundle for led_blink_ctrl: valid/ready plus the mode,
// half-period and burst-count payload.
interface led_blink_ctrl_if #(
  parameter int PERIOD_W = 16
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_mode;
  logic [PERIOD_W-1:0] cmd_half_period;
  logic [7:0]          cmd_burst;

  modport master (
    output cmd_valid, cmd_mode, cmd_half_period, cmd_burst,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_half_period, cmd_burst,
    output cmd_ready
  );

endinterface

// File: rtl/half_period_timer.sv
// Half-period counter: runs 0..half_period-1, flags expiry on the last count
// and restarts from 0 on expiry or on an explicit load.
module half_period_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                load,
  input  logic [PERIOD_W-1:0] half_period,
  output logic                expire
);

  logic [PERIOD_W-1:0] count;

  assign expire = (count == half_period - PERIOD_W'(1));

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset || load || expire) begin
      count <= '0;
    end else begin
      count <= count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// LED controller: OFF / ON / continuous BLINK / counted BURST, driven by a
// valid/ready command port; bursts hold off new commands until they finish.
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int PERIOD_W            = 16,
  parameter int DEFAULT_HALF_PERIOD = DEFAULT_HALF_PERIOD_CYC
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  led_blink_ctrl_if.slave       cmd,
  output logic [1:0]            LED,
  output logic                  busy,
  output logic                  done
);

  state_e              state;
  logic                lamp;
  logic                ready;
  logic [PERIOD_W-1:0] half_period;
  logic [7:0]          burst_left;
  logic                accept;
  logic                expire;
  logic [PERIOD_W-1:0] cmd_h_eff;
  mode_e               mode;

  assign accept        = cmd.cmd_valid && ready;
  assign mode          = mode_e'(cmd.cmd_mode);
  assign cmd_h_eff     = (cmd.cmd_half_period == '0) ? PERIOD_W'(DEFAULT_HALF_PERIOD)
                                                      : cmd.cmd_half_period;
  assign cmd.cmd_ready = ready;
  assign LED           = {~lamp, lamp};

  // Every accepted command restarts the timer, so an expiry in the accept cycle is dropped.
  half_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .load        (accept),
    .half_period (half_period),
    .expire      (expire)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= ST_OFF;
      lamp        <= 1'b0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      half_period <= PERIOD_W'(DEFAULT_HALF_PERIOD);
      burst_left  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        unique case (mode)
          MODE_OFF: begin
            state <= ST_OFF;
            lamp  <= 1'b0;
          end
          MODE_ON: begin
            state <= ST_ON;
            lamp  <= 1'b1;
          end
          MODE_BLINK: begin
            state       <= ST_BLINK;
            lamp        <= 1'b1;
            half_period <= cmd_h_eff;
          end
          MODE_BURST: begin
            half_period <= cmd_h_eff;
            burst_left  <= cmd.cmd_burst;
            if (cmd.cmd_burst == 8'd0) begin
              state <= ST_OFF;
              lamp  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_BURST_ON;
              lamp  <= 1'b1;
              busy  <= 1'b1;
              ready <= 1'b0;
            end
          end
        endcase
      end else if (expire) begin
        case (state)
          ST_BLINK: lamp <= ~lamp;
          ST_BURST_ON: begin
            state <= ST_BURST_OFF;
            lamp  <= 1'b0;
          end
          ST_BURST_OFF: begin
            if (burst_left == 8'd1) begin
              state <= ST_OFF;
              busy  <= 1'b0;
              ready <= 1'b1;
              done  <= 1'b1;
            end else begin
              burst_left <= burst_left - 8'd1;
              state      <= ST_BURST_ON;
              lamp       <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl: directed scenarios plus a random
// command stream, checked against an arithmetic model of the lamp waveform.
module tb_led_blink_ctrl;

  localparam int PW    = 16;
  localparam int DEF_H = 7;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [1:0] LED;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  led_blink_ctrl_if #(.PERIOD_W(PW)) cmd ();

  led_blink_ctrl #(
    .PERIOD_W            (PW),
    .DEFAULT_HALF_PERIOD (DEF_H)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cmd      (cmd.slave),
    .LED      (LED),
    .busy     (busy),
    .done     (done)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic lamp, input logic bsy,
                             input logic rdy, input logic dn);
    check({tag, ".led"},   8'(LED),           8'({~lamp, lamp}));
    check({tag, ".busy"},  8'(busy),          8'(bsy));
    check({tag, ".ready"}, 8'(cmd.cmd_ready), 8'(rdy));
    check({tag, ".done"},  8'(done),          8'(dn));
  endtask

  function automatic int eff(input int h);
    return (h == 0) ? DEF_H : h;
  endfunction

  // Lamp level k cycles after acceptance (k >= 1): H cycles at 1, H at 0, repeating.
  function automatic logic wave(input int k, input int h);
    return (((k - 1) / h) % 2) == 0;
  endfunction

  // Present one command in the current cycle; returns in the first cycle after acceptance.
  task automatic send(input logic [1:0] m, input int h, input int n);
    cmd.cmd_valid       = 1'b1;
    cmd.cmd_mode        = m;
    cmd.cmd_half_period = 16'(h);
    cmd.cmd_burst       = 8'(n);
    check("send.ready", 8'(cmd.cmd_ready), 8'd1);
    step();
    cmd.cmd_valid       = 1'b0;
    cmd.cmd_mode        = 2'($urandom);
    cmd.cmd_half_period = 16'($urandom);
    cmd.cmd_burst       = 8'($urandom);
  endtask

  task automatic run_level(input logic lamp, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      if (k > 1) step();
      check_state("level", lamp, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic run_blink(input int h, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      if (k > 1) step();
      check_state("blink", wave(k, h), 1'b0, 1'b1, 1'b0);
    end
  endtask

  // Burst of n pulses: 2*n*h busy cycles, then done in the first OFF cycle.
  // Random commands are offered while busy; none may be taken.
  task automatic run_burst(input int n, input int h, input int last);
    int total;
    total = 2 * n * h;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) step();
      check_state("burst", (k <= total) ? wave(k, h) : 1'b0,
                  k <= total, k > total, k == total + 1);
      cmd.cmd_valid = (k <= total) ? 1'($urandom) : 1'b0;
      cmd.cmd_mode  = 2'($urandom);
    end
    cmd.cmd_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] m;
    int         h;
    int         n;

    reset               = 1'b1;
    cmd.cmd_valid       = 1'b0;
    cmd.cmd_mode        = M_OFF;
    cmd.cmd_half_period = '0;
    cmd.cmd_burst       = '0;
    step();
    step();
    check_state("reset", 1'b0, 1'b0, 1'b1, 1'b0);

    // Idle after reset.
    reset = 1'b0;
    step();
    run_level(1'b0, 10);

    // BLINK H=4.
    send(M_BLINK, 4, 9);
    run_blink(4, 17);

    // Re-accepting BLINK mid-level restarts from lamp = 1.
    send(M_BLINK, 4, 0);
    run_blink(4, 6);
    send(M_BLINK, 2, 0);
    run_blink(2, 8);

    // H = 0 falls back to the default half-period; H = 1 toggles every cycle.
    send(M_BLINK, 0, 0);
    run_blink(DEF_H, 16);
    send(M_BLINK, 1, 0);
    run_blink(1, 6);

    // ON accepted on the expiry cycle of the first lamp = 1 level.
    send(M_BLINK, 3, 0);
    run_blink(3, 3);
    send(M_ON, 3, 0);
    run_level(1'b1, 8);

    // BURST N=3 H=2: done 13 cycles after acceptance.
    send(M_BURST, 2, 3);
    run_burst(3, 2, 14);

    // BURST N=0: immediate done, busy never rises.
    send(M_BURST, 5, 0);
    run_burst(0, 5, 3);

    // BURST N=5 H=3, reset during the 3rd pulse with a command offered under reset.
    send(M_BURST, 3, 5);
    run_burst(5, 3, 14);
    reset         = 1'b1;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_mode  = M_ON;
    step();
    check_state("rst_mid", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_state("rst_mid", 1'b0, 1'b0, 1'b1, 1'b0);
    reset         = 1'b0;
    cmd.cmd_valid = 1'b0;
    step();
    run_level(1'b0, 20);
    send(M_BURST, 1, 2);
    run_burst(2, 1, 6);

    // Random command stream.
    for (int it = 0; it < 24; it++) begin
      m = 2'($urandom_range(0, 3));
      h = $urandom_range(0, 4);
      n = $urandom_range(0, 3);
      send(m, h, n);
      case (m)
        M_OFF:   run_level(1'b0, $urandom_range(1, 5));
        M_ON:    run_level(1'b1, $urandom_range(1, 5));
        M_BLINK: run_blink(eff(h), $urandom_range(1, 3 * eff(h)));
        default: run_burst(n, eff(h), 2 * n * eff(h) + 2);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
